// File: rtl/md_sequencer.sv
// Issue/retire sequencer for the iterative multiply/divide unit: one op in flight,
// valid/ready writeback, hazard busy info. Define MD_TIMEOUT_EN to add a BUSY watchdog.
module md_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 40,
  parameter int unsigned MULT_EXC_CODE  = 4,
  parameter int unsigned DIV_EXC_CODE   = 5,
  parameter int unsigned RSTATUS_REG    = 30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [4:0]  req_rd,
  output logic [31:0] md_operandA,
  output logic [31:0] md_operandB,
  output logic        md_ctrl_MULT,
  output logic        md_ctrl_DIV,
  input  logic [31:0] md_result,
  input  logic        md_exception,
  input  logic        md_resultRDY,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [31:0] wb_result,
  output logic [4:0]  wb_rd,
  output logic        wb_exception,
  output logic        busy,
  output logic [4:0]  busy_rd
);

  typedef enum logic [1:0] {S_IDLE, S_START, S_BUSY, S_DONE} state_e;

  state_e      state_q, state_d;
  logic        op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  wrd_q, wrd_d;
  logic        exc_q, exc_d;

  logic [31:0] exc_code;
  assign exc_code = op_q ? 32'(DIV_EXC_CODE) : 32'(MULT_EXC_CODE);

`ifdef MD_TIMEOUT_EN
  localparam logic [5:0] TMO_LAST = 6'(TIMEOUT_CYCLES - 1);
  logic [5:0] tmo_q, tmo_d;
`endif

  // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latches).
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    rd_d    = rd_q;
    res_d   = res_q;
    wrd_d   = wrd_q;
    exc_d   = exc_q;
`ifdef MD_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = req_a;
          b_d     = req_b;
          rd_d    = req_rd;
          state_d = S_START;
        end
      end
      S_START: begin
        // The unit may still show the previous op's ready flag here, so it is not sampled.
        state_d = S_BUSY;
`ifdef MD_TIMEOUT_EN
        tmo_d   = '0;
`endif
      end
      S_BUSY: begin
        if (md_resultRDY) begin
          state_d = S_DONE;
          if (md_exception) begin
            res_d = exc_code;
            wrd_d = 5'(RSTATUS_REG);
            exc_d = 1'b1;
          end else begin
            res_d = md_result;
            wrd_d = rd_q;
            exc_d = 1'b0;
          end
        end
`ifdef MD_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          state_d = S_DONE;
          res_d   = exc_code;
          wrd_d   = 5'(RSTATUS_REG);
          exc_d   = 1'b1;
        end else begin
          tmo_d = tmo_q + 6'd1;
        end
`endif
      end
      S_DONE: begin
        if (wb_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      rd_q    <= '0;
      res_q   <= '0;
      wrd_q   <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rd_q    <= rd_d;
      res_q   <= res_d;
      wrd_q   <= wrd_d;
      exc_q   <= exc_d;
    end
  end

`ifdef MD_TIMEOUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) tmo_q <= '0;
    else        tmo_q <= tmo_d;
  end
`endif

  assign req_ready    = (state_q == S_IDLE);
  assign busy         = (state_q != S_IDLE);
  assign busy_rd      = busy ? rd_q : 5'd0;
  assign md_operandA  = busy ? a_q : 32'd0;
  assign md_operandB  = busy ? b_q : 32'd0;
  assign md_ctrl_MULT = (state_q == S_START) && !op_q;
  assign md_ctrl_DIV  = (state_q == S_START) &&  op_q;
  assign wb_valid     = (state_q == S_DONE);
  assign wb_result    = res_q;
  assign wb_rd        = wrd_q;
  assign wb_exception = exc_q;

endmodule
